// File: rtl/seq_pattern_detector_if.sv
// Serial-stream bus for seq_pattern_detector: qualified input bit, clear, and
// the registered detector outputs. match_count exists only under SEQDET_MATCH_COUNT_EN.
interface seq_pattern_detector_if #(
  parameter int PAT_W = 3
`ifdef SEQDET_MATCH_COUNT_EN
  , parameter int CNT_W = 8
`endif
);
  localparam int SW = $clog2(PAT_W + 1);

  logic          clr;
  logic          in_valid;
  logic          in;
  logic          match;
  logic [SW-1:0] state_o;
`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] match_count;

  modport master (output clr, in_valid, in, input match, state_o, match_count);
  modport slave  (input clr, in_valid, in, output match, state_o, match_count);
`else
  modport master (output clr, in_valid, in, input match, state_o);
  modport slave  (input clr, in_valid, in, output match, state_o);
`endif
endinterface

// File: rtl/seq_pattern_detector.sv
// Moore serial pattern detector with KMP fallback, optional overlap, input
// qualification and sync clear. SEQDET_MATCH_COUNT_EN adds a saturating match counter.
module seq_pattern_detector #(
  parameter int             PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter int             OVERLAP = 1
`ifdef SEQDET_MATCH_COUNT_EN
  , parameter int           CNT_W   = 8
`endif
) (
  input  logic                 clk,
  input  logic                 aresetn,
  seq_pattern_detector_if.slave bus
);
  localparam int SW = $clog2(PAT_W + 1);
  localparam int NS = 2 ** SW;
  localparam logic [SW-1:0] FULL = SW'(PAT_W);

  // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
  function automatic logic [SW-1:0] next_state(int k, logic b);
    logic [PAT_W:0] h;
    int len, best;
    logic ok;
    h = '0;
    for (int i = 0; i < PAT_W; i++)
      if (i < k) h[i] = PATTERN[PAT_W-1-i];
    h[k] = b;
    len  = k + 1;
    best = 0;
    for (int j = 1; j <= PAT_W; j++) begin
      if (j <= len) begin
        ok = 1'b1;
        for (int t = 0; t < PAT_W; t++)
          if (t < j) begin
            if (h[len-j+t] != PATTERN[PAT_W-1-t]) ok = 1'b0;
          end
        if (ok) best = j;
      end
    end
    return SW'(best);
  endfunction

  logic [SW-1:0] tbl0 [NS];
  logic [SW-1:0] tbl1 [NS];

  // FULL restarts from S0 when non-overlapping; encodings above FULL are unreachable.
  for (genvar k = 0; k < NS; k++) begin : g_tbl
    localparam int KS = (k > PAT_W || (k == PAT_W && OVERLAP == 0)) ? 0 : k;
    localparam logic [SW-1:0] N0 = (k <= PAT_W) ? next_state(KS, 1'b0) : '0;
    localparam logic [SW-1:0] N1 = (k <= PAT_W) ? next_state(KS, 1'b1) : '0;
    assign tbl0[k] = N0;
    assign tbl1[k] = N1;
  end

  logic [SW-1:0] state, state_nxt;

  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) state <= '0;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (bus.clr)           state_nxt = '0;
    else if (bus.in_valid) state_nxt = bus.in ? tbl1[state] : tbl0[state];
  end

  assign bus.match   = (state == FULL);
  assign bus.state_o = state;

`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn)     cnt <= '0;
    else if (bus.clr) cnt <= '0;
    else if (bus.in_valid && state_nxt == FULL && cnt != '1)
      cnt <= cnt + CNT_W'(1);

  assign bus.match_count = cnt;
`endif
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: four configurations side by side, table vectors,
// reset/clear sequences and random stimulus against a history-based model.
module tb_seq_pattern_detector;
  logic clk = 1'b0, aresetn = 1'b1, clr = 1'b0, vld = 1'b0, din = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] st [4];
  logic        mt [4];
`ifdef SEQDET_MATCH_COUNT_EN
  logic [31:0] ct [4];
`endif

  // d0: 101 overlap, d1: 101 non-overlap, d2: 1101 overlap, d3: 111 overlap (2-bit counter)
  for (genvar d = 0; d < 4; d++) begin : g_dut
    localparam int PW = (d == 2) ? 4 : 3;
    localparam logic [PW-1:0] PT = PW'((d == 2) ? 4'b1101 : (d == 3) ? 4'b0111 : 4'b0101);
    localparam int OV = (d == 1) ? 0 : 1;
`ifdef SEQDET_MATCH_COUNT_EN
    localparam int CW = (d == 3) ? 2 : 8;
`endif
    seq_pattern_detector_if #(.PAT_W(PW)
`ifdef SEQDET_MATCH_COUNT_EN
      , .CNT_W(CW)
`endif
    ) ifc ();
    assign ifc.clr      = clr;
    assign ifc.in_valid = vld;
    assign ifc.in       = din;
    seq_pattern_detector #(.PAT_W(PW), .PATTERN(PT), .OVERLAP(OV)
`ifdef SEQDET_MATCH_COUNT_EN
      , .CNT_W(CW)
`endif
    ) dut (.clk(clk), .aresetn(aresetn), .bus(ifc));
    assign st[d] = 32'(ifc.state_o);
    assign mt[d] = ifc.match;
`ifdef SEQDET_MATCH_COUNT_EN
    assign ct[d] = 32'(ifc.match_count);
`endif
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: raw history of accepted bits; state = longest suffix equal to a pattern prefix.
  int          pw   [4] = '{3, 3, 4, 3};
  logic [31:0] pat  [4] = '{32'd5, 32'd5, 32'd13, 32'd7};
  bit          ov   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int          cmax [4] = '{255, 255, 255, 3};
  logic [31:0] hv   [4];
  int          hl [4], ms [4], mc [4];

  task automatic model_reset(input int d);
    hv[d] = '0; hl[d] = 0; ms[d] = 0; mc[d] = 0;
  endtask

  task automatic model_step(input bit c, input bit v, input bit b);
    for (int d = 0; d < 4; d++) begin
      if (c) model_reset(d);
      else if (v) begin
        hv[d] = {hv[d][30:0], b};
        if (hl[d] < 32) hl[d]++;
        ms[d] = 0;
        for (int j = 1; j <= pw[d]; j++)
          if (j <= hl[d] && ((hv[d] & ((32'd1 << j) - 32'd1)) == (pat[d] >> (pw[d] - j))))
            ms[d] = j;
        if (ms[d] == pw[d]) begin
          if (mc[d] < cmax[d]) mc[d]++;
          if (!ov[d]) hl[d] = 0;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s state d%0d", tag, d), int'(st[d]), ms[d]);
      chk($sformatf("%s match d%0d", tag, d), int'(mt[d]), int'(ms[d] == pw[d]));
`ifdef SEQDET_MATCH_COUNT_EN
      chk($sformatf("%s count d%0d", tag, d), int'(ct[d]), mc[d]);
`endif
    end
  endtask

  task automatic step(input bit c, input bit v, input bit b);
    clr = c; vld = v; din = b;
    @(posedge clk); #1;
    model_step(c, v, b);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    aresetn = 1'b0;
    for (int d = 0; d < 4; d++) model_reset(d);
    #1;
    check_model(tag);
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  typedef struct packed {
    bit c, v, b;
    logic [3:0][2:0] s;
    logic [7:0] ca;
    logic [1:0] cd;
  } vec_t;

  function automatic vec_t mk(bit c, bit v, bit b, int s0, int s1, int s2, int s3, int ca, int cd);
    vec_t r;
    r.c = c; r.v = v; r.b = b;
    r.s[0] = 3'(s0); r.s[1] = 3'(s1); r.s[2] = 3'(s2); r.s[3] = 3'(s3);
    r.ca = 8'(ca); r.cd = 2'(cd);
    return r;
  endfunction

  localparam int NV = 27;
  vec_t tv [NV];

  initial begin
    // clr, in_valid, in | states d0..d3 | count d0, count d3
    tv[0]  = mk(1,0,0, 0,0,0,0, 0,0);
    tv[1]  = mk(0,1,1, 1,1,1,1, 0,0);
    tv[2]  = mk(0,1,0, 2,2,0,0, 0,0);
    tv[3]  = mk(0,1,1, 3,3,1,1, 1,0);
    tv[4]  = mk(0,1,0, 2,0,0,0, 1,0);
    tv[5]  = mk(0,1,1, 3,1,1,1, 2,0);
    tv[6]  = mk(1,0,0, 0,0,0,0, 0,0);
    tv[7]  = mk(0,1,1, 1,1,1,1, 0,0);
    tv[8]  = mk(0,1,1, 1,1,2,2, 0,0);
    tv[9]  = mk(0,1,1, 1,1,2,3, 0,1);
    tv[10] = mk(0,1,0, 2,2,3,0, 0,1);
    tv[11] = mk(0,1,1, 3,3,4,1, 1,1);
    tv[12] = mk(1,0,0, 0,0,0,0, 0,0);
    tv[13] = mk(0,1,1, 1,1,1,1, 0,0);
    tv[14] = mk(0,1,1, 1,1,2,2, 0,0);
    tv[15] = mk(0,1,1, 1,1,2,3, 0,1);
    tv[16] = mk(0,1,1, 1,1,2,3, 0,2);
    tv[17] = mk(0,1,1, 1,1,2,3, 0,3);
    tv[18] = mk(0,1,1, 1,1,2,3, 0,3);
    tv[19] = mk(1,0,0, 0,0,0,0, 0,0);
    tv[20] = mk(0,1,1, 1,1,1,1, 0,0);
    tv[21] = mk(0,1,0, 2,2,0,0, 0,0);
    tv[22] = mk(0,0,1, 2,2,0,0, 0,0);
    tv[23] = mk(0,0,1, 2,2,0,0, 0,0);
    tv[24] = mk(0,0,1, 2,2,0,0, 0,0);
    tv[25] = mk(0,1,1, 3,3,1,1, 1,0);
    tv[26] = mk(1,1,1, 0,0,0,0, 0,0);

    for (int d = 0; d < 4; d++) model_reset(d);
    #2 aresetn = 1'b0;
    #1 check_model("reset");
    repeat (2) @(posedge clk);
    #1 check_model("reset hold");
    @(negedge clk);
    aresetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(tv[i].c, tv[i].v, tv[i].b);
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("vec%0d state d%0d", i, d), int'(st[d]), int'(tv[i].s[d]));
        chk($sformatf("vec%0d match d%0d", i, d), int'(mt[d]), int'(int'(tv[i].s[d]) == pw[d]));
      end
`ifdef SEQDET_MATCH_COUNT_EN
      chk($sformatf("vec%0d count d0", i), int'(ct[0]), int'(tv[i].ca));
      chk($sformatf("vec%0d count d3", i), int'(ct[3]), int'(tv[i].cd));
`endif
    end

    // Mid-clock reset from S2 must clear outputs before any edge.
    step(0, 1, 1);
    step(0, 1, 0);
    chk("pre-reset state d0", int'(st[0]), 2);
    @(negedge clk);
    aresetn = 1'b0;
    for (int d = 0; d < 4; d++) model_reset(d);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("async reset state d%0d", d), int'(st[d]), 0);
      chk($sformatf("async reset match d%0d", d), int'(mt[d]), 0);
    end
    @(negedge clk);
    aresetn = 1'b1;

    // clr beats a qualified matching bit and drops the count.
    step(0, 1, 1); step(0, 1, 0); step(0, 1, 1); step(0, 1, 0);
    chk("pre-clr state d0", int'(st[0]), 2);
`ifdef SEQDET_MATCH_COUNT_EN
    chk("pre-clr count d0", int'(ct[0]), 1);
`endif
    step(1, 1, 1);
    check_model("clr");
    chk("clr state d0", int'(st[0]), 0);
`ifdef SEQDET_MATCH_COUNT_EN
    chk("clr count d0", int'(ct[0]), 0);
`endif

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset($sformatf("rnd reset @%0d", i));
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 75, 1'($urandom_range(0, 1)));
      check_model($sformatf("rnd @%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Registered, parametrised serial pattern-detecting Moore FSM: generalises the fixed 4-state "101" next-state logic to an arbitrary PAT_W-bit pattern, with selectable overlapping or non-overlapping detection, input qualification, synchronous clear and an optional saturating match counter. It sits on a one-bit serial stream behind a deserialiser/sampler and drives a registered match flag to downstream control logic.

## Interface

**Parameters**
- PAT_W, default 3: pattern length in bits; legal range 2..16.
- PATTERN, default 3'b101: pattern to detect, PAT_W bits wide; PATTERN[PAT_W-1] is the first bit received.
- OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
- CNT_W, default 8: match counter width; legal range 1..32.
- SW, derived: $clog2(PAT_W+1); state register width.

**Ports**
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk, input, 1: rising-edge clock.
- aresetn, input, 1: asynchronous, active-low reset.
- clr, input, 1: synchronous clear.
- in_valid, input, 1: qualifies `in` for the current edge.
- in, input, 1: serial data bit.
- match, output, 1: high while the state is FULL (state == PAT_W).
- state_o, output, SW: current state; equals the number of pattern bits currently matched.
- match_count, output, CNT_W: saturating count of completed matches (present only under the macro).

## Operation

- **States:** S0..S(PAT_W). Sk means the last k accepted bits equal PATTERN[PAT_W-1 -: k]. S(PAT_W) is FULL.
- **Transitions, from Sk with k < PAT_W:**
  - If `in` == PATTERN[PAT_W-1-k], go to S(k+1).
  - Otherwise go to the longest j such that the last j accepted bits, including `in`, equal the first j pattern bits. This is the KMP failure rule.
  - Compute the next-state table at elaboration time with a function or generate loop. Do not hard-code it.
- **From FULL:**
  - OVERLAP=1: apply the failure rule to the full pattern plus `in`.
  - OVERLAP=0: treat FULL as S0 and take S0's transition on `in`.
- **Reproduces the 101 case:** with PATTERN=3'b101 and OVERLAP=1:
  - FULL --1--> S1
  - FULL --0--> S2
- **Input qualification:** the state advances only on edges where in_valid=1. When in_valid=0, the state and all outputs hold.
- **Precedence on a rising edge:**
  - aresetn low (asynchronous) beats clr.
  - clr beats in_valid.
  - clr=1 forces S0 and clears match_count, regardless of in_valid and `in`.
- **match:** decoded from the state register only (Moore). No combinational path from `in` to `match`.
- **match_count:**
  - Increments by 1 on every qualified edge whose next state is FULL. This includes FULL→FULL, e.g. PATTERN=3'b111, OVERLAP=1, input 1.
  - Saturates at 2^CNT_W−1 and never wraps.

## Timing

- **Reset values** while aresetn=0: state_o=0, match=0, match_count=0. Takes effect immediately, without waiting for a clock edge. Release is synchronous to the next rising edge of clk.
- **Latency:** `match` rises on the same clk edge that samples the final pattern bit, i.e. one cycle after that bit is presented.
- **match duration:** stays high until the next qualified edge or clr. Downstream logic treats a rising edge, or match & in_valid, as an event.
- **Reset mid-pattern:** partial progress is discarded and detection restarts from S0.

## Configuration

- **Macro:** SEQDET_MATCH_COUNT_EN.
- **Defined:** the match_count port and the CNT_W-bit saturating counter exist as described above.
- **Undefined:**
  - The match_count port and counter are omitted.
  - CNT_W is ignored.
  - clr only affects state.
  - FSM behaviour is otherwise identical.

## Test plan

- **Overlapping detection:** PATTERN=3'b101, OVERLAP=1, in_valid=1, stream 1,0,1,0,1 → `match` high after the 3rd and 5th edges; state_o after the 5 edges is 1,2,3,2,3; match_count=2.
- **Non-overlapping detection:** same stream with OVERLAP=0 → `match` high after the 3rd edge only; state_o after the 5 edges is 1,2,3,0,1; match_count=1.
- **Failure fallback:** PAT_W=4, PATTERN=4'b1101, stream 1,1,1,0,1 → state_o after the 5 edges is 1,2,2,3,4; `match` high after the 5th edge.
- **Input qualification:** stream 1,0 with in_valid=1, then 3 cycles with in_valid=0 and in=1, then 1 with in_valid=1 → state holds at 2 during the gap; `match` asserts on the final edge.
- **Reset and clear:**
  - aresetn pulsed low at mid-clock while in S2 → outputs 0 immediately.
  - Then clr=1 together with in_valid=1 on a matching bit → state 0, match_count 0.
- **Saturation and build variant:**
  - CNT_W=2, PATTERN=3'b111, OVERLAP=1, six 1s → match_count 1,2,3,3 on edges 3..6.
  - Rebuild without SEQDET_MATCH_COUNT_EN → port absent; match and state sequence identical.
